alu_issue_stage: RTL
====================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- DATA_W, 32, operand and register width.
- NREG, 32, register count; register addresses are 5 bits.

REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on its rising edge.
- rst_n, in, 1, reset, asynchronous and active-low.
- in_valid, in, 1, instruction offered.
- in_ready, out, 1, instruction accepted this cycle when in_valid is also high.
- in_instr, in, 32, R-type instruction: rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
- wb_en, in, 1, writeback strobe from downstream.
- wb_addr, in, 5, writeback register address.
- wb_data, in, DATA_W, writeback value.
- out_valid, out, 1, issued operation held for the ALU.
- out_ready, in, 1, ALU/next stage consumes the operation.
- out_alu_ctl, out, 2, ALU operation code: 0 add, 1 sub, 2 shift left, 3 arithmetic shift right.
- out_a, out, DATA_W, ALU operand A.
- out_b, out, DATA_W, ALU operand B.
- out_rd, out, 5, destination register travelling with the operation.
- illegal, out, 1, sticky unsupported-funct flag.

Function
REQ-003 Decode SHALL map funct values to ALU operations as follows:
- 0x20 -> ctl 0, A = R[rs], B = R[rt].
- 0x22 -> ctl 1, A = R[rs], B = R[rt].
- 0x00 -> ctl 2, A = R[rt], B = zero-extended shamt.
- 0x03 -> ctl 3, A = R[rt], B = zero-extended shamt.
- Any other funct is illegal.

REQ-004 The block SHALL contain an NREG x DATA_W register file; R0 SHALL read as 0, and writes to R0 SHALL be ignored.

REQ-005 When wb_en is high, the block SHALL write wb_data to R[wb_addr] at the clock edge and SHALL clear pending[wb_addr].

REQ-006 A scoreboard SHALL hold one pending bit per register; pending[0] SHALL always be 0.

REQ-007 The hazard condition SHALL be true when any of the following is pending:
- rd.
- rs, for add and sub only.
- rt, for all legal operations.

REQ-008 in_ready SHALL equal (!hazard) AND (!out_valid OR out_ready), and SHALL be combinational.

REQ-009 On acceptance of a legal instruction, the block SHALL load the out_* registers, set out_valid = 1 and set pending[rd] (unless rd = 0); issue latency is one cycle from accept to out_valid.

REQ-010 An accepted illegal instruction SHALL be consumed without issue: out_valid is unchanged by it, illegal is set to 1, and illegal holds until reset.

REQ-011 When out_valid = 1 and out_ready = 0, all out_* signals SHALL hold stable.

REQ-012 When out_valid = 1, out_ready = 1 and no acceptance occurs in the same cycle, out_valid SHALL fall to 0 on the next edge.

REQ-013 When a writeback clears and an issue sets the same pending bit in the same cycle, the set SHALL win.

REQ-014 A writeback to a non-pending register SHALL update the register and leave its pending bit at 0.

Reset
REQ-015 While rst_n = 0, the block SHALL immediately drive the following, independent of clk:
- out_valid = 0.
- out_alu_ctl = 0, out_a = 0, out_b = 0, out_rd = 0.
- illegal = 0.
- All pending bits = 0.
- All registers = 0.

REQ-016 A reset asserted mid-operation SHALL discard the held operation and all scoreboard state; a writeback in the same cycle SHALL be lost.

Configuration
REQ-017 With ALU_ISSUE_FWD_EN defined, the block SHALL provide same-cycle writeback forwarding:
- Operand reads SHALL return wb_data when wb_en = 1 and wb_addr equals the read address (nonzero).
- The hazard check SHALL use pending with wb_addr already cleared, so a dependent instruction issues in the writeback cycle.

REQ-018 Without ALU_ISSUE_FWD_EN, there SHALL be no bypass, and a dependent instruction SHALL issue no earlier than the cycle after its writeback.

Structure
REQ-019 A shared package alu_issue_pkg SHALL hold:
- The 2-bit ALU control typedef with the four named codes.
- The funct constants (0x20, 0x22, 0x00, 0x03).
- The instruction field bit positions.

REQ-020 The register file with its R0 rule and bypass mux SHALL be one sub-module, alu_issue_regfile, providing two read ports and one write port; decode, scoreboard and output register SHALL remain in alu_issue_stage.

Verification
REQ-021 The bench SHALL cover these directed scenarios (stimulus -> required response):
- After reset, preload R1 = 5 and R2 = 3 via wb, then issue add rd = 3 -> next cycle out_valid = 1, ctl = 0, A = 5, B = 3, rd = 3, pending[3] = 1.
- sra rt = 1 (R1 = 0x80000000), shamt = 4 -> ctl = 3, A = 0x80000000, B = 4.
- Issue sub rd = 4, then add rs = 4 while pending -> in_ready = 0 until wb_addr = 4; the add issues in the wb cycle with FWD_EN defined (A = wb_data), and one cycle later without it.
- Hold out_ready = 0 for 3 cycles with a new instruction offered -> out_* stable, in_ready = 0, no second acceptance.
- Offer funct 0x25 -> accepted, illegal = 1 sticky, out_valid unchanged.
- Assert rst_n low while out_valid = 1 and pending[5] = 1 -> out_valid = 0 and pending cleared immediately; an instruction using R5 is accepted after reset release.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: ALU control codes, the
// supported R-type funct values, instruction field positions and the
// funct decoder used by the stage.
package alu_issue_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_SLL = 2'd2,
      ALU_SRA = 2'd3
   } alu_ctl_e;

   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_SLL = 6'h00;
   localparam logic [5:0] FUNCT_SRA = 6'h03;

   // R-type field positions (all register fields are 5 bits wide)
   localparam int RS_LSB = 21;
   localparam int RT_LSB = 16;
   localparam int RD_LSB = 11;
   localparam int SH_LSB = 6;
   localparam int FN_LSB = 0;
   localparam int RA_W   = 5;

   typedef struct packed {
      logic     legal;
      logic     shift;   // shifts take A from rt and B from shamt
      alu_ctl_e ctl;
   } dec_t;

   function automatic dec_t decode(input logic [5:0] funct);
      dec_t d;
      d = '{legal: 1'b1, shift: 1'b0, ctl: ALU_ADD};
      case (funct)
         FUNCT_ADD: d.ctl = ALU_ADD;
         FUNCT_SUB: d.ctl = ALU_SUB;
         FUNCT_SLL: begin d.ctl = ALU_SLL; d.shift = 1'b1; end
         FUNCT_SRA: begin d.ctl = ALU_SRA; d.shift = 1'b1; end
         default:   d.legal = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Register file for the ALU issue stage: NREG x DATA_W, two read ports,
// one write port. R0 reads as zero and ignores writes.
// Optional macro ALU_ISSUE_FWD_EN: a read of the address being written
// this cycle returns the write data (same-cycle bypass).
// Ports: clk, rst_n (async low, clears all registers), we/waddr/wdata
// write port, ra_addr/ra_data and rb_addr/rb_data read ports.
module alu_issue_regfile
   import alu_issue_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREG   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [RA_W-1:0]   waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [RA_W-1:0]   ra_addr,
   output logic [DATA_W-1:0] ra_data,
   input  logic [RA_W-1:0]   rb_addr,
   output logic [DATA_W-1:0] rb_data
);

   logic [DATA_W-1:0] regs [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we && waddr != '0) begin
         regs[waddr] <= wdata;
      end
   end

`ifdef ALU_ISSUE_FWD_EN
   assign ra_data = (ra_addr == '0) ? '0 : (we && waddr == ra_addr) ? wdata : regs[ra_addr];
   assign rb_data = (rb_addr == '0) ? '0 : (we && waddr == rb_addr) ? wdata : regs[rb_addr];
`else
   assign ra_data = (ra_addr == '0) ? '0 : regs[ra_addr];
   assign rb_data = (rb_addr == '0) ? '0 : regs[rb_addr];
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes R-type add/sub/sll/sra, reads operands from the
// register file, blocks on a per-register pending scoreboard, and holds the
// issued operation in an output register with valid/ready handshake.
// Optional macro ALU_ISSUE_FWD_EN: same-cycle writeback forwarding, so an
// instruction waiting on a register issues in its writeback cycle.
// Ports: clk, rst_n (async low); in_valid/in_ready/in_instr instruction
// input; wb_en/wb_addr/wb_data writeback; out_valid/out_ready handshake
// with out_alu_ctl/out_a/out_b/out_rd payload; illegal sticky flag.
module alu_issue_stage
   import alu_issue_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREG   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic              wb_en,
   input  logic [RA_W-1:0]   wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        out_alu_ctl,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [RA_W-1:0]   out_rd,
   output logic              illegal
);

   logic [RA_W-1:0]   rs, rt, rd, shamt;
   dec_t              dec;
   logic [RA_W-1:0]   ra_addr;
   logic [DATA_W-1:0] ra_data, rb_data;
   logic [DATA_W-1:0] opnd_b;
   logic [NREG-1:0]   pending, pend_chk, wb_clr, iss_set;
   logic              hazard, accept, issue;

   assign rs    = in_instr[RS_LSB +: RA_W];
   assign rt    = in_instr[RT_LSB +: RA_W];
   assign rd    = in_instr[RD_LSB +: RA_W];
   assign shamt = in_instr[SH_LSB +: RA_W];
   assign dec   = decode(in_instr[FN_LSB +: 6]);

   assign ra_addr = dec.shift ? rt : rs;
   assign opnd_b  = dec.shift ? {{(DATA_W-RA_W){1'b0}}, shamt} : rb_data;

   alu_issue_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (wb_en),
      .waddr   (wb_addr),
      .wdata   (wb_data),
      .ra_addr (ra_addr),
      .ra_data (ra_data),
      .rb_addr (rt),
      .rb_data (rb_data)
   );

   always_comb begin
      wb_clr = '0;
      if (wb_en) wb_clr[wb_addr] = 1'b1;
   end

`ifdef ALU_ISSUE_FWD_EN
   // the register being written this cycle is already resolved via bypass
   assign pend_chk = pending & ~wb_clr;
`else
   assign pend_chk = pending;
`endif

   // rd is always checked (WAW); rs only feeds add/sub; rt feeds every legal op
   assign hazard   = pend_chk[rd]
                   | (dec.legal && !dec.shift && pend_chk[rs])
                   | (dec.legal && pend_chk[rt]);
   assign in_ready = !hazard && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign issue    = accept && dec.legal;

   always_comb begin
      iss_set = '0;
      if (issue) iss_set[rd] = 1'b1;
      iss_set[0] = 1'b0;
   end

   // set is OR'd after the clear so an issue wins over a same-cycle writeback
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending <= '0;
      else        pending <= (pending & ~wb_clr) | iss_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_alu_ctl <= '0;
         out_a       <= '0;
         out_b       <= '0;
         out_rd      <= '0;
         illegal     <= 1'b0;
      end else begin
         if (issue) begin
            out_valid   <= 1'b1;
            out_alu_ctl <= dec.ctl;
            out_a       <= ra_data;
            out_b       <= opnd_b;
            out_rd      <= rd;
         end else if (out_ready) begin
            out_valid   <= 1'b0;
         end
         if (accept && !dec.legal) illegal <= 1'b1;
      end
   end

endmodule
